// File: rtl/alu_issue_queue_if.sv
// Command, ALU-operand and result bundle for alu_issue_queue.
// Valid/ready: a transfer happens on a rising edge where valid and ready are both high;
// the sender holds its payload stable while valid is high and ready is low.
interface alu_issue_queue_if #(
    parameter int WIDTH = 16
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [3:0]       cmd_op;
    logic [WIDTH-1:0] cmd_a;
    logic [WIDTH-1:0] cmd_b;
    logic             cmd_use_acc;

    logic [3:0]       alu_op;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [WIDTH-1:0] alu_result;

    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_data;
    logic             busy;

    modport master (
        output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_use_acc,
        input  cmd_ready,
        input  alu_op, alu_a, alu_b,
        output alu_result,
        input  res_valid, res_data, busy,
        output res_ready
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_use_acc,
        output cmd_ready,
        output alu_op, alu_a, alu_b,
        input  alu_result,
        output res_valid, res_data, busy,
        input  res_ready
    );
endinterface

// File: rtl/alu_issue_queue.sv
// Four-entry command FIFO feeding registered ALU operands and a held result register.
// Define ALU_ACC_FWD_EN to build the accumulator-forwarding path for operand A.
module alu_issue_queue #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    alu_issue_queue_if.slave bus,
    output logic [1:0]       dbg_state
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        HOLD  = 2'd2
    } state_t;

`ifdef ALU_ACC_FWD_EN
    localparam int ENTRY_W = 2 * WIDTH + 5;
`else
    localparam int ENTRY_W = 2 * WIDTH + 4;
`endif

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [1:0]         wr_ptr;
    logic [1:0]         rd_ptr;
    logic [2:0]         count;
    logic [ENTRY_W-1:0] wr_entry;
    logic [ENTRY_W-1:0] rd_entry;
    logic               push;
    logic               pop;
    logic               nonempty;
    logic [WIDTH-1:0]   pop_a;

    state_t             state;
    logic [3:0]         op_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [WIDTH-1:0]   res_q;
    logic               res_valid_q;

    // A full FIFO refuses even when a pop lands on the same edge.
    assign bus.cmd_ready = (count < 3'(DEPTH)) && !rst;
    assign push          = bus.cmd_valid && bus.cmd_ready;
    assign nonempty      = (count != 3'd0);
    assign pop           = nonempty && ((state == IDLE) || (state == HOLD && bus.res_ready));
    assign rd_entry      = mem[rd_ptr];

`ifdef ALU_ACC_FWD_EN
    logic [WIDTH-1:0] acc;
    assign wr_entry = {bus.cmd_use_acc, bus.cmd_op, bus.cmd_a, bus.cmd_b};
    // acc is already current here: a pop only ever follows a capture.
    assign pop_a    = rd_entry[2*WIDTH+4] ? acc : rd_entry[2*WIDTH-1:WIDTH];
`else
    logic unused_use_acc;
    assign unused_use_acc = bus.cmd_use_acc;
    assign wr_entry = {bus.cmd_op, bus.cmd_a, bus.cmd_b};
    assign pop_a    = rd_entry[2*WIDTH-1:WIDTH];
`endif

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= 2'd0;
            rd_ptr <= 2'd0;
            count  <= 3'd0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 2'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 2'd1;
            end
            count <= count + {2'b00, push} - {2'b00, pop};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            op_q        <= 4'd0;
            a_q         <= '0;
            b_q         <= '0;
            res_q       <= '0;
            res_valid_q <= 1'b0;
`ifdef ALU_ACC_FWD_EN
            acc         <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        op_q  <= rd_entry[2*WIDTH+3:2*WIDTH];
                        a_q   <= pop_a;
                        b_q   <= rd_entry[WIDTH-1:0];
                        state <= DRIVE;
                    end
                end
                DRIVE: begin
                    res_q       <= bus.alu_result;
                    res_valid_q <= 1'b1;
`ifdef ALU_ACC_FWD_EN
                    acc         <= bus.alu_result;
`endif
                    state       <= HOLD;
                end
                HOLD: begin
                    if (bus.res_ready) begin
                        res_valid_q <= 1'b0;
                        if (pop) begin
                            op_q  <= rd_entry[2*WIDTH+3:2*WIDTH];
                            a_q   <= pop_a;
                            b_q   <= rd_entry[WIDTH-1:0];
                            state <= DRIVE;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.alu_op    = op_q;
    assign bus.alu_a     = a_q;
    assign bus.alu_b     = b_q;
    assign bus.res_data  = res_q;
    assign bus.res_valid = res_valid_q;
    assign bus.busy      = (state != IDLE) || nonempty;
    assign dbg_state     = state;
endmodule

// File: tb/tb_alu_issue_queue.sv
// Directed scoreboard bench for alu_issue_queue with a small add/subtract ALU model.
`timescale 1ns/1ps
module tb_alu_issue_queue;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [1:0]   dbg_state;
    int           n_tests = 0;
    int           n_fail  = 0;
    int           cyc     = 0;
    logic [W-1:0] exp_q[$];
    int           res_cyc[$];
    logic [W-1:0] held;
    logic [W-1:0] ta;
    logic [W-1:0] tb_b;
    logic [3:0]   top;
    logic         seen_valid;

    alu_issue_queue_if #(.WIDTH(W)) bus ();

    alu_issue_queue #(.DEPTH(4), .WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.slave),
        .dbg_state (dbg_state)
    );

    // clock/reset block
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000ns");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [W-1:0] alu_model(input logic [3:0] op, input logic [W-1:0] a,
                                               input logic [W-1:0] b);
        case (op)
            4'h2:    alu_model = a + b;
            4'h3:    alu_model = a - b;
            default: alu_model = a ^ b;
        endcase
    endfunction

    assign bus.alu_result = alu_model(bus.alu_op, bus.alu_a, bus.alu_b);

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // scoreboard: every completed result handshake pops one expectation
    always @(negedge clk) begin
        if (!rst && bus.res_valid === 1'b1 && bus.res_ready === 1'b1) begin
            res_cyc.push_back(cyc);
            check("result_expected", 16'(exp_q.size() != 0), 16'd1);
            if (exp_q.size() != 0) begin
                check("result_data", bus.res_data, exp_q.pop_front());
            end
        end
    end

    // driver tasks
    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic ua, input logic [W-1:0] exp);
        int waited;
        waited          = 0;
        bus.cmd_valid   = 1'b1;
        bus.cmd_op      = op;
        bus.cmd_a       = a;
        bus.cmd_b       = b;
        bus.cmd_use_acc = ua;
        @(negedge clk);
        while (bus.cmd_ready !== 1'b1 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        check("cmd_accept", 16'(bus.cmd_ready), 16'd1);
        if (bus.cmd_ready === 1'b1) begin
            exp_q.push_back(exp);
        end
        @(posedge clk);
        #1;
        bus.cmd_valid   = 1'b0;
        bus.cmd_use_acc = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || bus.busy !== 1'b0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_drained"}, 16'(exp_q.size()), 16'd0);
        check({tag, "_idle"}, 16'(bus.busy), 16'd0);
    endtask

    initial begin
        bus.cmd_valid   = 1'b0;
        bus.cmd_op      = 4'd0;
        bus.cmd_a       = '0;
        bus.cmd_b       = '0;
        bus.cmd_use_acc = 1'b0;
        bus.res_ready   = 1'b1;
        rst             = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // reset values while rst is high
        check("rst_cmd_ready", 16'(bus.cmd_ready), 16'd0);
        check("rst_res_valid", 16'(bus.res_valid), 16'd0);
        check("rst_res_data", bus.res_data, 16'h0000);
        check("rst_alu_op", 16'(bus.alu_op), 16'd0);
        check("rst_alu_a", bus.alu_a, 16'h0000);
        check("rst_alu_b", bus.alu_b, 16'h0000);
        check("rst_busy", 16'(bus.busy), 16'd0);
        rst = 1'b0;
        @(negedge clk);
        check("cmd_ready_after_rst", 16'(bus.cmd_ready), 16'd1);
        sync();

        // single op: latency and one-cycle result pulse
        send(4'h2, 16'h0003, 16'h0004, 1'b0, 16'h0007);
        @(negedge clk);
        check("lat_t1_res_valid", 16'(bus.res_valid), 16'd0);
        @(negedge clk);
        check("lat_t2_res_valid", 16'(bus.res_valid), 16'd0);
        check("lat_t2_state_drive", 16'(dbg_state), 16'd1);
        check("lat_t2_alu_op", 16'(bus.alu_op), 16'd2);
        check("lat_t2_alu_a", bus.alu_a, 16'h0003);
        check("lat_t2_alu_b", bus.alu_b, 16'h0004);
        @(negedge clk);
        check("lat_t3_res_valid", 16'(bus.res_valid), 16'd1);
        check("lat_t3_res_data", bus.res_data, 16'h0007);
        @(negedge clk);
        check("pulse_res_valid", 16'(bus.res_valid), 16'd0);
        wait_drain("single");
        sync();

        // 16-bit wrap in both directions
        send(4'h2, 16'hFFFF, 16'h0002, 1'b0, 16'h0001);
        send(4'h3, 16'h0000, 16'h0001, 1'b0, 16'hFFFF);
        wait_drain("wrap");
        sync();

        // backpressure: result held, FIFO fills, then ordered drain at 1 per 2 cycles
        bus.res_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            ta   = 16'(16'h1000 * (i + 1));
            tb_b = 16'(i + 1);
            send(4'h2, ta, tb_b, 1'b0, ta + tb_b);
        end
        @(negedge clk);
        check("full_cmd_ready", 16'(bus.cmd_ready), 16'd0);
        check("full_state_hold", 16'(dbg_state), 16'd2);
        check("full_first_result", bus.res_data, 16'h1001);
        held = bus.res_data;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("held_res_valid", 16'(bus.res_valid), 16'd1);
            check("held_res_data", bus.res_data, held);
        end
        res_cyc.delete();
        sync();
        bus.res_ready = 1'b1;
        wait_drain("backpressure");
        check("bp_result_count", 16'(res_cyc.size()), 16'd5);
        for (int i = 1; i < 5; i++) begin
            if (i < res_cyc.size()) begin
                check("bp_spacing", 16'(res_cyc[i] - res_cyc[i-1]), 16'd2);
            end
        end
        sync();

        // chaining through the accumulator
        send(4'h2, 16'h0005, 16'h0001, 1'b0, 16'h0006);
`ifdef ALU_ACC_FWD_EN
        send(4'h2, 16'h1234, 16'h000A, 1'b1, 16'h0010);
`else
        send(4'h2, 16'h1234, 16'h000A, 1'b1, 16'h123E);
`endif
        wait_drain("chain");
        sync();

        // reset while DRIVE with two entries still queued
        bus.res_ready = 1'b0;
        send(4'h2, 16'h0001, 16'h0001, 1'b0, 16'h0002);
        send(4'h2, 16'h0002, 16'h0002, 1'b0, 16'h0004);
        send(4'h2, 16'h0003, 16'h0003, 1'b0, 16'h0006);
        send(4'h2, 16'h0004, 16'h0004, 1'b0, 16'h0008);
        bus.res_ready = 1'b1;
        sync();
        check("pre_rst_state_drive", 16'(dbg_state), 16'd1);
        rst = 1'b1;
        sync();
        rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("mid_rst_res_valid", 16'(bus.res_valid), 16'd0);
        check("mid_rst_busy", 16'(bus.busy), 16'd0);
        check("mid_rst_alu_op", 16'(bus.alu_op), 16'd0);
        check("mid_rst_alu_a", bus.alu_a, 16'h0000);
        check("mid_rst_alu_b", bus.alu_b, 16'h0000);
        check("mid_rst_cmd_ready", 16'(bus.cmd_ready), 16'd1);
        seen_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.res_valid !== 1'b0) seen_valid = 1'b1;
        end
        check("no_stale_result", 16'(seen_valid), 16'd0);
        sync();

        // nine ops back to back across the pointer wrap
        for (int i = 0; i < 9; i++) begin
            top  = 4'($urandom_range(2, 3));
            ta   = 16'($urandom_range(0, 65535));
            tb_b = 16'(16'h0100 + i * 3);
            send(top, ta, tb_b, 1'b0, (top == 4'h2) ? ta + tb_b : ta - tb_b);
        end
        wait_drain("ptr_wrap");

        // final report
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
